// File: rtl/apb_cmd_master_if.sv
// Command, response and APB3 signal bundle for apb_cmd_master.
// master = the bridge itself, slave = requester plus peripheral side.
interface apb_cmd_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;

  logic [ADDR_W-1:0] PADDR;
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  rsp_ready,
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output rsp_ready,
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_cmd_master.sv
// APB3 initiator: one valid/ready command in, one APB transfer out,
// one valid/ready response back, with a wait-state timeout.
module apb_cmd_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                PCLK,
  input  logic                PRESETN,
  apb_cmd_master_if.master    bus
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_t;

  localparam logic [15:0] TMO = 16'(TIMEOUT);

  state_t            state_q;
  logic [15:0]       cnt_q;
  logic [15:0]       cnt_d;
  logic              tmo_hit;

  logic [ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0] pwdata_q;
  logic              pwrite_q;
  logic              psel_q;
  logic              penable_q;

  logic              rvalid_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic              tmo_q;

  assign cnt_d   = (cnt_q == 16'hFFFF) ? cnt_q
                                       : cnt_q + 16'd1;
  assign tmo_hit = (TMO != 16'd0) && (cnt_q == TMO);

  // Held low while in reset even though the FSM already sits in IDLE.
  assign bus.req_ready   = PRESETN && (state_q == IDLE);

  assign bus.PADDR       = paddr_q;
  assign bus.PWDATA      = pwdata_q;
  assign bus.PWRITE      = pwrite_q;
  assign bus.PSEL        = psel_q;
  assign bus.PENABLE     = penable_q;
  assign bus.rsp_valid   = rvalid_q;
  assign bus.rsp_rdata   = rdata_q;
  assign bus.rsp_err     = err_q;
  assign bus.rsp_timeout = tmo_q;

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pwrite_q  <= 1'b0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            paddr_q  <= bus.req_addr;
            pwrite_q <= bus.req_write;
            pwdata_q <= bus.req_write ? bus.req_wdata
                                      : '0;
            psel_q   <= 1'b1;
            state_q  <= SETUP;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          cnt_q     <= '0;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          // PREADY takes priority over a timeout in the same cycle.
          if (bus.PREADY) begin
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            rdata_q   <= pwrite_q ? '0 : bus.PRDATA;
            err_q     <= bus.PSLVERR;
            tmo_q     <= 1'b0;
            rvalid_q  <= 1'b1;
            state_q   <= RESP;
          end else if (tmo_hit) begin
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b1;
            tmo_q     <= 1'b1;
            rvalid_q  <= 1'b1;
            state_q   <= RESP;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rvalid_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Self-checking bench for apb_cmd_master: a transaction-level model
// predicts every bus cycle from the wait count planned per command.
module tb_apb_cmd_master;

  localparam int TO = 4;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          w;
    bit          err;
    bit          noise;
    int          hold;
    int          gap;
  } cmd_t;

  logic PCLK;
  logic PRESETN;

  apb_cmd_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  apb_cmd_master #(
    .ADDR_W (32),
    .DATA_W (32),
    .TIMEOUT(TO)
  ) dut (
    .PCLK   (PCLK),
    .PRESETN(PRESETN),
    .bus    (bus)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  int nvec = 0;
  int nmis = 0;

  cmd_t q[$];
  cmd_t cur;
  bit   busy;
  int   t;
  int   A;
  int   hold_left;
  int   cyc;
  int   last_acc;
  int   prev_acc;

  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  bit          m_wr;
  logic [31:0] e_rdata;
  bit          e_err;
  bit          e_to;

  int          psel_cnt;
  int          pen_cnt;
  int          rv_t;
  logic [31:0] rv_rdata;
  bit          rv_err;
  bit          rv_to;
  logic [31:0] obs_pwdata;

  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic cmd_t mk(bit wr, logic [31:0] a,
                              logic [31:0] d, logic [31:0] rd,
                              int w, bit e, bit nz,
                              int h, int g);
    cmd_t c;
    c.wr = wr; c.addr = a; c.wdata = d; c.rdata = rd;
    c.w = w; c.err = e; c.noise = nz;
    c.hold = h; c.gap = g;
    return c;
  endfunction

  task automatic drive();
    int k;
    if (q.size() > 0 && q[0].gap == 0) begin
      bus.req_valid = 1'b1;
      bus.req_write = q[0].wr;
      bus.req_addr  = q[0].addr;
      bus.req_wdata = q[0].wdata;
    end else begin
      bus.req_valid = 1'b0;
      bus.req_write = 1'($urandom);
      bus.req_addr  = $urandom;
      bus.req_wdata = $urandom;
    end
    k = t - 1;
    if (busy && t >= 2 && t <= A + 1) begin
      if (k > cur.w) begin
        bus.PREADY  = 1'b1;
        bus.PSLVERR = cur.err;
        bus.PRDATA  = cur.rdata;
      end else begin
        bus.PREADY  = 1'b0;
        bus.PSLVERR = cur.noise ? 1'b1 : 1'($urandom);
        bus.PRDATA  = $urandom;
      end
    end else begin
      bus.PREADY  = 1'($urandom);
      bus.PSLVERR = 1'($urandom);
      bus.PRDATA  = $urandom;
    end
    if (busy && t >= A + 2) begin
      bus.rsp_ready = (hold_left == 0);
      if (hold_left > 0) hold_left--;
    end else begin
      bus.rsp_ready = 1'($urandom);
    end
  endtask

  // Outcome of a transfer follows from its planned wait count alone.
  task automatic update();
    if (!busy) begin
      if (bus.req_valid) begin
        cur = q.pop_front();
        busy = 1; t = 1;
        m_addr  = cur.addr;
        m_wr    = cur.wr;
        m_wdata = cur.wr ? cur.wdata : 32'h0;
        if (TO != 0 && cur.w >= TO + 1) begin
          A = TO + 1;
          e_err = 1; e_to = 1; e_rdata = 0;
        end else begin
          A = cur.w + 1;
          e_err = cur.err; e_to = 0;
          e_rdata = cur.wr ? 32'h0 : cur.rdata;
        end
        hold_left = cur.hold;
        psel_cnt = 0; pen_cnt = 0; rv_t = 0;
        prev_acc = last_acc; last_acc = cyc;
      end else if (q.size() > 0 && q[0].gap > 0) begin
        q[0].gap = q[0].gap - 1;
      end
    end else if (t >= A + 2 && bus.rsp_ready) begin
      busy = 0;
    end else begin
      t++;
    end
  endtask

  task automatic observe();
    psel_cnt += int'(bus.PSEL);
    pen_cnt  += int'(bus.PENABLE);
    if (bus.PSEL && !bus.PENABLE) obs_pwdata = bus.PWDATA;
    if (bus.rsp_valid && rv_t == 0) begin
      rv_t     = t;
      rv_rdata = bus.rsp_rdata;
      rv_err   = bus.rsp_err;
      rv_to    = bus.rsp_timeout;
    end
  endtask

  task automatic compare();
    bit rv;
    rv = busy && t >= A + 2;
    chk("req_ready", 64'(bus.req_ready), 64'(!busy));
    chk("psel", 64'(bus.PSEL), 64'(busy && t <= A + 1));
    chk("penable", 64'(bus.PENABLE),
        64'(busy && t >= 2 && t <= A + 1));
    chk("rsp_valid", 64'(bus.rsp_valid), 64'(rv));
    chk("paddr", 64'(bus.PADDR), 64'(m_addr));
    chk("pwrite", 64'(bus.PWRITE), 64'(m_wr));
    chk("pwdata", 64'(bus.PWDATA), 64'(m_wdata));
    if (rv) begin
      chk("rsp_rdata", 64'(bus.rsp_rdata), 64'(e_rdata));
      chk("rsp_err", 64'(bus.rsp_err), 64'(e_err));
      chk("rsp_timeout", 64'(bus.rsp_timeout), 64'(e_to));
    end
  endtask

  task automatic cycle();
    @(posedge PCLK);
    #1;
    cyc++;
    update();
    observe();
    @(negedge PCLK);
    compare();
    drive();
  endtask

  task automatic run_all();
    int g;
    g = 0;
    while ((q.size() > 0 || busy) && g < 4000) begin
      cycle();
      g++;
    end
    chk("drain_done", 64'({q.size() != 0, busy}), 64'(0));
  endtask

  task automatic model_reset();
    busy = 0; t = 0; A = 0; hold_left = 0;
    q.delete();
    m_addr = 0; m_wdata = 0; m_wr = 0;
  endtask

  task automatic chk_all_zero(string nm);
    chk({nm, "_ctl"},
        64'({bus.req_ready, bus.rsp_valid, bus.rsp_err,
             bus.rsp_timeout, bus.PSEL, bus.PENABLE,
             bus.PWRITE}), 64'(0));
    chk({nm, "_paddr"}, 64'(bus.PADDR), 64'(0));
    chk({nm, "_pwdata"}, 64'(bus.PWDATA), 64'(0));
    chk({nm, "_rdata"}, 64'(bus.rsp_rdata), 64'(0));
  endtask

  initial begin
    cyc = 0; last_acc = 0; prev_acc = 0;
    model_reset();
    PRESETN = 1'b0;
    drive();
    #3;
    chk_all_zero("reset");
    #20;
    @(negedge PCLK);
    PRESETN = 1'b1;
    drive();
    cycle();

    // zero-wait write
    q.push_back(mk(1, 32'h7000_0004, 32'hA5, 0, 0, 0, 0, 0, 1));
    run_all();
    chk("wr_psel_cycles", 64'(psel_cnt), 64'(2));
    chk("wr_pen_cycles", 64'(pen_cnt), 64'(1));
    chk("wr_pwdata", 64'(obs_pwdata), 64'(32'hA5));
    chk("wr_rsp_lat", 64'(rv_t), 64'(3));
    chk("wr_rdata", 64'(rv_rdata), 64'(0));
    chk("wr_err", 64'(rv_err), 64'(0));

    // read with three wait states
    q.push_back(mk(0, 32'h7000_0000, 32'hDEAD, 32'h3C,
                   3, 0, 0, 0, 1));
    run_all();
    chk("rd_rsp_lat", 64'(rv_t), 64'(6));
    chk("rd_rdata", 64'(rv_rdata), 64'(32'h3C));
    chk("rd_pwdata", 64'(obs_pwdata), 64'(0));

    // slave error, then PSLVERR noise during waits only
    q.push_back(mk(0, 32'h7000_0010, 0, 32'h11, 2, 1, 0, 0, 1));
    run_all();
    chk("err_err", 64'(rv_err), 64'(1));
    chk("err_to", 64'(rv_to), 64'(0));
    chk("err_rdata", 64'(rv_rdata), 64'(32'h11));
    q.push_back(mk(0, 32'h7000_0014, 0, 32'h22, 3, 0, 1, 0, 1));
    run_all();
    chk("noise_err", 64'(rv_err), 64'(0));

    // timeout, then PREADY on the last allowed cycle
    q.push_back(mk(0, 32'h7000_0020, 0, 32'h77, 100, 0, 0, 0, 1));
    run_all();
    chk("tmo_psel_cycles", 64'(psel_cnt), 64'(6));
    chk("tmo_pen_cycles", 64'(pen_cnt), 64'(5));
    chk("tmo_rsp_lat", 64'(rv_t), 64'(7));
    chk("tmo_flags", 64'({rv_err, rv_to}), 64'(2'b11));
    chk("tmo_rdata", 64'(rv_rdata), 64'(0));
    q.push_back(mk(0, 32'h7000_0024, 0, 32'h5A, 4, 0, 0, 0, 1));
    run_all();
    chk("edge_pen_cycles", 64'(pen_cnt), 64'(5));
    chk("edge_flags", 64'({rv_err, rv_to}), 64'(0));
    chk("edge_rdata", 64'(rv_rdata), 64'(32'h5A));

    // backpressure with next command pending, then min spacing
    q.push_back(mk(1, 32'h7000_0030, 32'h1234, 0, 1, 0, 0, 10, 1));
    q.push_back(mk(0, 32'h7000_0034, 0, 32'h99, 0, 0, 0, 0, 0));
    run_all();
    chk("bp_spacing", 64'(last_acc - prev_acc), 64'(15));
    q.push_back(mk(1, 32'h7000_0040, 32'h1, 0, 0, 0, 0, 0, 1));
    q.push_back(mk(1, 32'h7000_0044, 32'h2, 0, 0, 0, 0, 0, 0));
    run_all();
    chk("min_spacing", 64'(last_acc - prev_acc), 64'(4));

    for (int i = 0; i < 80; i++) begin
      q.push_back(mk(1'($urandom), $urandom, $urandom, $urandom,
                     $urandom_range(0, 7), 1'($urandom),
                     1'($urandom), $urandom_range(0, 3),
                     $urandom_range(0, 2)));
    end
    run_all();

    // asynchronous reset during a wait state
    q.push_back(mk(0, 32'h7000_0050, 0, 32'h66, 50, 0, 0, 0, 0));
    begin
      int g;
      g = 0;
      while (!(busy && t == 4) && g < 50) begin
        cycle();
        g++;
      end
    end
    chk("mid_reached", 64'(t), 64'(4));
    chk("mid_psel", 64'(bus.PSEL), 64'(1));
    #2;
    PRESETN = 1'b0;
    #1;
    chk_all_zero("mid_rst");
    model_reset();
    repeat (2) @(posedge PCLK);
    @(negedge PCLK);
    PRESETN = 1'b1;
    drive();
    repeat (4) cycle();
    chk("post_rst_rvalid", 64'(bus.rsp_valid), 64'(0));
    chk("post_rst_ready", 64'(bus.req_ready), 64'(1));
    q.push_back(mk(0, 32'h7000_0054, 0, 32'hC3, 1, 0, 0, 0, 1));
    run_all();
    chk("post_rst_rdata", 64'(rv_rdata), 64'(32'hC3));

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nmis);
    $finish;
  end

endmodule
